// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and constants for the pipeline stage buffer and its helpers.
package pipe_stage_buf_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } pipe_st_e;

  localparam logic FlushOn = 1'b1;

  function automatic logic [1:0] st_occupancy(pipe_st_e st);
    logic [1:0] occ;
    case (st)
      StFull:  occ = 2'd1;
      StSkid:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with optional skid entry, flush-to-NOP and
// stall/bubble performance counters.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned       DATA_W    = 160,
  parameter bit                SKID_EN   = 1'b1,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int unsigned       CNT_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        occupancy_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  pipe_st_e          state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              up_ready, up_fire, dn_valid, dn_fire;

  assign dn_valid = (state_q != StEmpty);
  assign dn_fire  = dn_valid & dn_ready_i;
  assign up_fire  = up_valid_i & up_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (up_fire) begin
          state_d = StFull;
          main_d  = up_data_i;
        end
      end
      StFull: begin
        if (up_fire && dn_fire) begin
          main_d = up_data_i;
        end else if (up_fire) begin
          // Only reachable with the skid entry present; otherwise up_ready implies dn_ready.
          state_d = StSkid;
          skid_d  = up_data_i;
        end else if (dn_fire) begin
          state_d = StEmpty;
          main_d  = NOP_VALUE;
        end
      end
      StSkid: begin
        if (dn_fire) begin
          state_d = StFull;
          main_d  = skid_q;
          skid_d  = NOP_VALUE;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush_i == FlushOn) begin
      state_d = StEmpty;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      main_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  if (SKID_EN) begin : g_skid
    logic up_ready_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        skid_q     <= NOP_VALUE;
        up_ready_q <= 1'b1;
      end else begin
        skid_q     <= skid_d;
        up_ready_q <= (state_d != StSkid);
      end
    end

    assign up_ready = up_ready_q;
  end else begin : g_no_skid
    logic unused_skid;

    assign skid_q      = NOP_VALUE;
    assign up_ready    = ~dn_valid | dn_ready_i;
    assign unused_skid = ^skid_d;
  end

  assign up_ready_o  = up_ready;
  assign dn_valid_o  = dn_valid;
  assign dn_data_o   = main_q;
  assign occupancy_o = st_occupancy(state_q);

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (cnt_clr_i),
    .inc_i (dn_valid & ~dn_ready_i),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (cnt_clr_i),
    .inc_i (~dn_valid & dn_ready_i),
    .cnt_o (bubble_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a skid instance and a no-skid instance share stimulus and are
// checked every cycle against a FIFO-level model, plus literal spot checks.
module tb_pipe_stage_buf;

  localparam logic [7:0] NOP = 8'hF0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       up_valid = 1'b1;
  logic [7:0] up_data = 8'hA5;
  logic       dn_ready = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       a_up_ready, a_dn_valid, b_up_ready, b_dn_valid;
  logic [7:0] a_dn_data, b_dn_data;
  logic [1:0] a_occ, b_occ;
  logic [3:0] a_stall, a_bubble;
  logic [7:0] b_stall, b_bubble;

  int n_vec = 0;
  int n_err = 0;

  // Model: per instance a FIFO of up to 2 payloads plus saturating counters.
  logic [7:0] mdat [2][2];
  int mcnt [2] = '{0, 0};
  int mstall [2] = '{0, 0};
  int mbub [2] = '{0, 0};
  int mmax [2] = '{15, 255};

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .DATA_W(8), .SKID_EN(1'b1), .NOP_VALUE(NOP), .CNT_W(4)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .up_valid_i(up_valid),
    .up_ready_o(a_up_ready), .up_data_i(up_data), .dn_valid_o(a_dn_valid),
    .dn_ready_i(dn_ready), .dn_data_o(a_dn_data), .occupancy_o(a_occ),
    .cnt_clr_i(cnt_clr), .stall_cnt_o(a_stall), .bubble_cnt_o(a_bubble)
  );

  pipe_stage_buf #(
    .DATA_W(8), .SKID_EN(1'b0), .NOP_VALUE(NOP), .CNT_W(8)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .up_valid_i(up_valid),
    .up_ready_o(b_up_ready), .up_data_i(up_data), .dn_valid_o(b_dn_valid),
    .dn_ready_i(dn_ready), .dn_data_o(b_dn_data), .occupancy_o(b_occ),
    .cnt_clr_i(cnt_clr), .stall_cnt_o(b_stall), .bubble_cnt_o(b_bubble)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready(int k);
    if (k == 0) return (mcnt[0] < 2);
    return (mcnt[1] == 0) || dn_ready;
  endfunction

  function automatic logic [7:0] exp_data(int k);
    return (mcnt[k] > 0) ? mdat[k][0] : NOP;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mcnt[k] = 0;
        mstall[k] = 0;
        mbub[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit rdy, dv, upf, dnf;
        rdy = exp_ready(k);
        dv  = (mcnt[k] > 0);
        upf = up_valid && rdy;
        dnf = dv && dn_ready;
        if (cnt_clr) begin
          mstall[k] = 0;
          mbub[k] = 0;
        end else begin
          if (dv && !dn_ready && mstall[k] < mmax[k]) mstall[k]++;
          if (!dv && dn_ready && mbub[k] < mmax[k]) mbub[k]++;
        end
        if (dnf) begin
          mdat[k][0] = mdat[k][1];
          mcnt[k]--;
        end
        if (flush) begin
          mcnt[k] = 0;
        end else if (upf) begin
          mdat[k][mcnt[k]] = up_data;
          mcnt[k]++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("a_dn_valid", 32'(a_dn_valid), 32'(mcnt[0] > 0));
    chk("a_dn_data", 32'(a_dn_data), 32'(exp_data(0)));
    chk("a_up_ready", 32'(a_up_ready), 32'(exp_ready(0)));
    chk("a_occupancy", 32'(a_occ), 32'(mcnt[0]));
    chk("a_stall_cnt", 32'(a_stall), 32'(mstall[0]));
    chk("a_bubble_cnt", 32'(a_bubble), 32'(mbub[0]));
    chk("b_dn_valid", 32'(b_dn_valid), 32'(mcnt[1] > 0));
    chk("b_dn_data", 32'(b_dn_data), 32'(exp_data(1)));
    chk("b_up_ready", 32'(b_up_ready), 32'(exp_ready(1)));
    chk("b_occupancy", 32'(b_occ), 32'(mcnt[1]));
    chk("b_stall_cnt", 32'(b_stall), 32'(mstall[1]));
    chk("b_bubble_cnt", 32'(b_bubble), 32'(mbub[1]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) tick();
    chk("lit_rst_a_valid", 32'(a_dn_valid), 32'd0);
    chk("lit_rst_a_data", 32'(a_dn_data), 32'hF0);
    chk("lit_rst_a_ready", 32'(a_up_ready), 32'd1);
    chk("lit_rst_b_ready", 32'(b_up_ready), 32'd1);
    chk("lit_rst_a_stall", 32'(a_stall), 32'd0);
    chk("lit_rst_a_bubble", 32'(a_bubble), 32'd0);
    chk("lit_rst_b_data", 32'(b_dn_data), 32'hF0);

    rst_n = 1'b1; up_valid = 1'b0; dn_ready = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      up_valid = 1'b1;
      up_data = 8'(i);
      tick();
      chk("lit_stream_a", 32'(a_dn_data), 32'(i));
      chk("lit_stream_b", 32'(b_dn_data), 32'(i));
    end
    up_valid = 1'b0;
    tick();
    chk("lit_drain_a_valid", 32'(a_dn_valid), 32'd0);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; dn_ready = 1'b0; up_valid = 1'b1; up_data = 8'h11;
    tick();
    up_data = 8'h22;
    tick();
    up_valid = 1'b0;
    repeat (3) tick();
    chk("lit_skid_a_occ", 32'(a_occ), 32'd2);
    chk("lit_skid_a_ready", 32'(a_up_ready), 32'd0);
    chk("lit_skid_a_data", 32'(a_dn_data), 32'h11);
    chk("lit_skid_a_stall", 32'(a_stall), 32'd4);
    chk("lit_skid_b_occ", 32'(b_occ), 32'd1);
    dn_ready = 1'b1;
    tick();
    chk("lit_skid_a_second", 32'(a_dn_data), 32'h22);
    chk("lit_skid_a_occ1", 32'(a_occ), 32'd1);
    tick();
    chk("lit_skid_a_empty", 32'(a_dn_valid), 32'd0);
    chk("lit_skid_a_stall_hold", 32'(a_stall), 32'd4);

    up_valid = 1'b1; up_data = 8'h33;
    tick();
    dn_ready = 1'b0; up_data = 8'h44;
    #1;
    chk("lit_noskid_b_ready", 32'(b_up_ready), 32'd0);
    tick();
    chk("lit_noskid_b_hold", 32'(b_dn_data), 32'h33);
    dn_ready = 1'b1;
    tick();
    chk("lit_noskid_b_next", 32'(b_dn_data), 32'h44);
    chk("lit_noskid_a_next", 32'(a_dn_data), 32'h44);
    up_valid = 1'b0;
    repeat (2) tick();

    dn_ready = 1'b0; up_valid = 1'b1; up_data = 8'h55;
    tick();
    up_data = 8'h66;
    tick();
    chk("lit_flush_pre_occ", 32'(a_occ), 32'd2);
    flush = 1'b1; up_data = 8'h77;
    tick();
    flush = 1'b0; up_valid = 1'b0;
    chk("lit_flush_a_valid", 32'(a_dn_valid), 32'd0);
    chk("lit_flush_a_data", 32'(a_dn_data), 32'hF0);
    chk("lit_flush_a_ready", 32'(a_up_ready), 32'd1);
    chk("lit_flush_a_occ", 32'(a_occ), 32'd0);
    tick();
    chk("lit_flush_dropped", 32'(a_dn_valid), 32'd0);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; up_valid = 1'b1; up_data = 8'h88;
    tick();
    up_valid = 1'b0;
    repeat (20) tick();
    chk("lit_sat_a_stall", 32'(a_stall), 32'd15);
    chk("lit_sat_b_stall", 32'(b_stall), 32'd20);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("lit_clr_a_stall", 32'(a_stall), 32'd0);
    chk("lit_clr_b_stall", 32'(b_stall), 32'd0);

    #3;
    rst_n = 1'b0;
    #1;
    chk("lit_async_a_valid", 32'(a_dn_valid), 32'd0);
    chk("lit_async_a_occ", 32'(a_occ), 32'd0);
    chk("lit_async_b_valid", 32'(b_dn_valid), 32'd0);
    tick();
    rst_n = 1'b1; dn_ready = 1'b1; up_valid = 1'b1; up_data = 8'h99;
    tick();
    chk("lit_after_rst_a", 32'(a_dn_data), 32'h99);
    up_valid = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
